// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pipeline_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead queue of fetched instructions; flush wins over push/pop.
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_entry,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot, so push into a full queue is fine when it pops too
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wr_entry;
  end

  // empty queue presents zeros rather than stale storage
  assign head = empty ? '{pc: 32'h0, inst: NOP_INST, err: 1'b0} : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues credit-limited word requests,
// queues responses for decode and discards stale responses after a redirect.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h1000,
  parameter int          DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        fetch_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   ret_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          stopped;
  logic          full;
  logic          empty;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          misaligned;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // queued entries plus in-flight requests may never exceed the queue size
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign req_valid   = !rst && !redirect_valid && !stopped && (credit_used < (CW+1)'(DEPTH));
  assign req_addr    = fetch_pc;
  assign req_fire    = req_valid && req_ready;

  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign push        = resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign wr_entry    = '{pc: ret_pc, inst: resp_data, err: resp_err};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign inst_valid = !empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_err   = head.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= START_ADDR;
      ret_pc      <= START_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
      stopped     <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        ret_pc   <= redirect_pc;
        // everything still in flight after this cycle belongs to the old path
        drop_cnt <= outstanding - CW'(resp_valid);
        stopped  <= misaligned;
        if (misaligned) fetch_err <= 1'b1;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'(INST_BYTES);
        if (resp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            ret_pc <= ret_pc + 32'(INST_BYTES);
            if (resp_err) begin
              stopped   <= 1'b1;
              fetch_err <= 1'b1;
            end
          end
        end
      end
    end
  end

  // the credit rule makes an enqueue into a full, non-draining queue impossible
  always_ff @(posedge clk) begin
    if (!rst) a_no_overflow: assert (!(push && full && !pop));
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench for fetch_queue against a queue-level reference model.
module tb_fetch_queue;
  import pipeline_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_err, fetch_err;
  logic [31:0] inst, inst_pc;

  always #5 clk = ~clk;

  fetch_queue #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .fetch_err      (fetch_err)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
    logic        err;
  } mreq_t;

  mreq_t        pend[$];   // memory-side in-flight requests, tagged by path epoch
  fetch_entry_t expq[$];   // what decode should currently see, in order
  int           epoch = 0;
  int           cyc = 0;
  logic [31:0]  m_pc = START;
  logic         m_stopped = 1'b0;
  logic         m_ferr = 1'b0;
  int           lat_min = 1, lat_max = 1, err_pct = 0;
  logic [31:0]  err_addr = 32'hFFFF_FFFF;
  int           n_chk = 0, n_fail = 0;
  int           dut_fires = 0;
  logic         chk_zero = 1'b0;
  logic         await_first = 1'b0;
  logic [31:0]  last_redir = START;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c5a_9617;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // one clock: drive memory, check at negedge, advance the model at posedge
  task automatic cycle();
    logic  resp_now, mrv, pop_now;
    mreq_t r;
    resp_now   = !rst && pend.size() > 0 && pend[0].due <= cyc;
    resp_valid = resp_now;
    resp_data  = resp_now ? mem_data(pend[0].addr) : $urandom;
    resp_err   = resp_now ? pend[0].err : 1'b0;
    mrv = !rst && !redirect_valid && !m_stopped && (expq.size() + pend.size() < DEPTH);
    #4;
    chk("req_valid", req_valid, mrv);
    if (mrv) chk("req_addr", req_addr, m_pc);
    chk("inst_valid", inst_valid, expq.size() > 0);
    if (expq.size() > 0) begin
      chk("inst", inst, expq[0].inst);
      chk("inst_pc", inst_pc, expq[0].pc);
      chk("inst_err", inst_err, expq[0].err);
    end
    chk("fetch_err", fetch_err, m_ferr);
    if (chk_zero) begin
      chk("reset_inst", inst, 32'h0);
      chk("reset_inst_pc", inst_pc, 32'h0);
      chk("reset_inst_err", inst_err, 1'b0);
      chk_zero = 1'b0;
    end
    if (await_first && !rst && !redirect_valid && inst_valid && inst_ready) begin
      chk("first_pc_after_redirect", inst_pc, last_redir);
      await_first = 1'b0;
    end
    if (req_valid && req_ready) dut_fires++;
    pop_now = expq.size() > 0 && inst_ready;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      expq.delete();
      m_pc = START;
      m_stopped = 1'b0;
      m_ferr = 1'b0;
      epoch++;
    end else if (redirect_valid) begin
      expq.delete();
      if (resp_now) r = pend.pop_front();
      epoch++;
      m_pc = redirect_pc;
      m_stopped = (redirect_pc[1:0] != 2'b00);
      if (m_stopped) m_ferr = 1'b1;
    end else begin
      if (pop_now) void'(expq.pop_front());
      if (resp_now) begin
        r = pend.pop_front();
        if (r.epoch == epoch) begin
          expq.push_back('{pc: r.addr, inst: mem_data(r.addr), err: r.err});
          if (r.err) begin
            m_stopped = 1'b1;
            m_ferr = 1'b1;
          end
        end
      end
      if (mrv && req_ready) begin
        pend.push_back('{addr: m_pc, epoch: epoch, due: cyc + $urandom_range(lat_min, lat_max),
                         err: (m_pc == err_addr) || (err_pct != 0 && $urandom_range(0, 99) < err_pct)});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
    chk_zero = 1'b1;
    await_first = 1'b1;
    last_redir = START;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    await_first = (pc[1:0] == 2'b00);
    last_redir = pc;
    cycle();
    redirect_valid = 1'b0;
    redirect_pc = $urandom;
  endtask

  initial begin
    int r;
    rst = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    resp_valid = 1'b0; resp_data = 32'h0; resp_err = 1'b0;
    @(posedge clk); #1;

    // streaming with single-cycle memory
    do_reset(2);
    repeat (20) cycle();

    // decode stall fills credits, then drains in order
    do_reset(1);
    inst_ready = 1'b0;
    dut_fires = 0;
    repeat (10) cycle();
    chk("stall_accepts", dut_fires, DEPTH);
    inst_ready = 1'b1;
    repeat (12) cycle();

    // slow memory with requests in flight, then redirect
    lat_min = 3; lat_max = 3;
    do_reset(1);
    repeat (6) cycle();
    redirect_to(32'h2000);
    repeat (15) cycle();

    // redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    repeat (10) cycle();
    redirect_to(32'h4000);
    repeat (10) cycle();

    // memory fault stops fetch until redirect
    do_reset(1);
    err_addr = 32'h1008;
    repeat (15) cycle();
    err_addr = 32'hFFFF_FFFF;
    redirect_to(32'h3000);
    repeat (12) cycle();

    // misaligned redirect, then reset mid-stream
    redirect_to(32'h2002);
    repeat (8) cycle();
    redirect_to(32'h2100);
    repeat (5) cycle();
    do_reset(1);
    repeat (10) cycle();

    // PC wrap
    redirect_to(32'hFFFF_FFF8);
    repeat (10) cycle();

    // random traffic
    lat_min = 1; lat_max = 4; err_pct = 2;
    for (int i = 0; i < 800; i++) begin
      req_ready  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      if (r < 3)       redirect_to($urandom & 32'hFFFF_FFFC);
      else if (r == 3) redirect_to(($urandom & 32'hFFFF_FFFC) | 32'(1 + $urandom_range(0, 2)));
      else if (r == 4) do_reset(1);
      else             cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
